// File: rtl/wb_stage.sv
// wb_stage: MEM/WB stage driving the register-file write port; optional bypass copy under WB_BYPASS_EN
module wb_stage #(
   parameter int DW    = 32,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mem_valid,
   output logic             mem_ready,
   input  logic             wb_hold,
   input  logic             flush,
   input  logic [4:0]       mem_dest,
   input  logic             mem_regwrite,
   input  logic             mem_memtoreg,
   input  logic             mem_link,
   input  logic [1:0]       load_size,
   input  logic             load_unsigned,
   input  logic [DW-1:0]    alu_result,
   input  logic [DW-1:0]    load_data,
   input  logic [DW-1:0]    pc_plus4,
   output logic [4:0]       write_reg,
   output logic [DW-1:0]    write_data,
   output logic             RegWrite,
   output logic             fwd_valid,
   output logic [4:0]       fwd_reg,
   output logic [DW-1:0]    fwd_data,
   output logic [CNT_W-1:0] retired_count
);
   logic          accept;
   logic [7:0]    lb;
   logic [15:0]   lh;
   logic [DW-1:0] load_val;
   logic [DW-1:0] result;
   assign mem_ready = !wb_hold;
   assign accept    = mem_valid && !wb_hold && !flush;
   // big-endian lane extraction and extension, then link > load > ALU select
   always_comb begin
      lb = alu_result[1:0] == 2'd0 ? load_data[31:24] :
           alu_result[1:0] == 2'd1 ? load_data[23:16] :
           alu_result[1:0] == 2'd2 ? load_data[15:8]  : load_data[7:0];
      lh = alu_result[1] ? load_data[15:0] : load_data[31:16];
      load_val = load_size == 2'b10 ? {{(DW-8){~load_unsigned & lb[7]}}, lb} :
                 load_size == 2'b01 ? {{(DW-16){~load_unsigned & lh[15]}}, lh} : load_data;
      result = mem_link ? pc_plus4 + DW'(4) : mem_memtoreg ? load_val : alu_result;
   end
   // one-shot write strobe; address/data captured on every accepted beat and held otherwise
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         RegWrite      <= 1'b0;
         write_reg     <= '0;
         write_data    <= '0;
         retired_count <= '0;
      end else begin
         RegWrite <= accept && mem_regwrite && mem_dest != 5'd0;
         if (accept) begin
            write_reg     <= mem_dest;
            write_data    <= result;
            retired_count <= retired_count + 1'b1;
         end
      end
   end
`ifdef WB_BYPASS_EN
   // bypass registers load on the same edge as the write port and mirror it
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fwd_valid <= 1'b0;
         fwd_reg   <= '0;
         fwd_data  <= '0;
      end else begin
         fwd_valid <= accept && mem_regwrite && mem_dest != 5'd0;
         if (accept) begin
            fwd_reg  <= mem_dest;
            fwd_data <= result;
         end
      end
   end
`else
   assign fwd_valid = 1'b0;
   assign fwd_reg   = '0;
   assign fwd_data  = '0;
`endif
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: table-driven vectors plus hold/flush/reset sequences for wb_stage
module tb_wb_stage;
   logic        clk = 1'b0;
   logic        rst;
   logic        mem_valid, mem_ready, wb_hold, flush;
   logic [4:0]  mem_dest;
   logic        mem_regwrite, mem_memtoreg, mem_link;
   logic [1:0]  load_size;
   logic        load_unsigned;
   logic [31:0] alu_result, load_data, pc_plus4;
   logic [4:0]  write_reg;
   logic [31:0] write_data;
   logic        RegWrite, fwd_valid;
   logic [4:0]  fwd_reg;
   logic [31:0] fwd_data, retired_count;
   int checks = 0;
   int failures = 0;
   logic [31:0] cnt_exp = 0;

   wb_stage #(.DW(32), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_ready(mem_ready),
      .wb_hold(wb_hold), .flush(flush), .mem_dest(mem_dest),
      .mem_regwrite(mem_regwrite), .mem_memtoreg(mem_memtoreg), .mem_link(mem_link),
      .load_size(load_size), .load_unsigned(load_unsigned), .alu_result(alu_result),
      .load_data(load_data), .pc_plus4(pc_plus4), .write_reg(write_reg),
      .write_data(write_data), .RegWrite(RegWrite), .fwd_valid(fwd_valid),
      .fwd_reg(fwd_reg), .fwd_data(fwd_data), .retired_count(retired_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        valid, hold, fl;
      logic [4:0]  dest;
      logic        rw, m2r, link;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] alu, pc;
      logic        exp_rw, chk;
      logic [4:0]  exp_reg;
      logic [31:0] exp_data;
      logic        inc;
   } vec_t;

   localparam logic [31:0] LD = 32'h80FF7F01;
   vec_t v [18];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic check_write(input string tag, input logic rw, input logic chk,
                              input logic [4:0] r, input logic [31:0] d);
      check({tag, " RegWrite"}, {31'd0, RegWrite}, {31'd0, rw});
      check({tag, " count"}, retired_count, cnt_exp);
      if (chk) begin
         check({tag, " write_reg"}, {27'd0, write_reg}, {27'd0, r});
         check({tag, " write_data"}, write_data, d);
      end
`ifdef WB_BYPASS_EN
      check({tag, " fwd_valid"}, {31'd0, fwd_valid}, {31'd0, rw});
      if (chk) begin
         check({tag, " fwd_reg"}, {27'd0, fwd_reg}, {27'd0, r});
         check({tag, " fwd_data"}, fwd_data, d);
      end
`else
      check({tag, " fwd_valid"}, {31'd0, fwd_valid}, 32'd0);
      check({tag, " fwd_reg/data"}, fwd_data | {27'd0, fwd_reg}, 32'd0);
`endif
   endtask

   task automatic idle();
      mem_valid = 0; wb_hold = 0; flush = 0; mem_dest = 0; mem_regwrite = 0;
      mem_memtoreg = 0; mem_link = 0; load_size = 0; load_unsigned = 0;
      alu_result = 0; pc_plus4 = 0;
   endtask

   task automatic beat(input logic [4:0] d, input logic [31:0] a);
      mem_valid = 1; mem_dest = d; mem_regwrite = 1; alu_result = a;
      mem_memtoreg = 0; mem_link = 0;
   endtask

   initial begin
      //       vld hld fl dst rw m2r lnk size uns alu          pc            erw chk ereg edata         inc
      v[0]  = '{1, 0, 0, 5,  1, 0, 0, 2'b00, 0, 32'h12345678, 32'h0,        1, 1, 5,  32'h12345678, 1};
      v[1]  = '{1, 0, 0, 8,  1, 1, 0, 2'b10, 0, 32'h00001001, 32'h0,        1, 1, 8,  32'hFFFFFFFF, 1};
      v[2]  = '{1, 0, 0, 9,  1, 1, 0, 2'b10, 0, 32'h00001002, 32'h0,        1, 1, 9,  32'h0000007F, 1};
      v[3]  = '{1, 0, 0, 10, 1, 1, 0, 2'b01, 1, 32'h00001002, 32'h0,        1, 1, 10, 32'h00007F01, 1};
      v[4]  = '{1, 0, 0, 11, 1, 1, 0, 2'b11, 0, 32'h00001003, 32'h0,        1, 1, 11, 32'h80FF7F01, 1};
      v[5]  = '{1, 0, 0, 12, 1, 1, 0, 2'b10, 1, 32'h00001000, 32'h0,        1, 1, 12, 32'h00000080, 1};
      v[6]  = '{1, 0, 0, 13, 1, 1, 0, 2'b10, 0, 32'h00001003, 32'h0,        1, 1, 13, 32'h00000001, 1};
      v[7]  = '{1, 0, 0, 14, 1, 1, 0, 2'b01, 0, 32'h00001001, 32'h0,        1, 1, 14, 32'hFFFF80FF, 1};
      v[8]  = '{1, 0, 0, 15, 1, 1, 0, 2'b00, 1, 32'h00001003, 32'h0,        1, 1, 15, 32'h80FF7F01, 1};
      v[9]  = '{1, 0, 0, 31, 1, 1, 1, 2'b10, 0, 32'h00000055, 32'h00400010, 1, 1, 31, 32'h00400014, 1};
      v[10] = '{1, 0, 0, 2,  1, 0, 1, 2'b00, 0, 32'h00000055, 32'hFFFFFFFC, 1, 1, 2,  32'h00000000, 1};
      v[11] = '{1, 0, 0, 0,  1, 0, 0, 2'b00, 0, 32'h0000AAAA, 32'h0,        0, 0, 0,  32'h0,        1};
      v[12] = '{1, 0, 0, 3,  0, 0, 0, 2'b00, 0, 32'h0000BBBB, 32'h0,        0, 0, 0,  32'h0,        1};
      v[13] = '{0, 0, 0, 4,  1, 0, 0, 2'b00, 0, 32'h0000CCCC, 32'h0,        0, 0, 0,  32'h0,        0};
      v[14] = '{1, 1, 0, 4,  1, 0, 0, 2'b00, 0, 32'h0000CCCC, 32'h0,        0, 0, 0,  32'h0,        0};
      v[15] = '{1, 0, 1, 4,  1, 0, 0, 2'b00, 0, 32'h0000CCCC, 32'h0,        0, 0, 0,  32'h0,        0};
      v[16] = '{1, 1, 1, 4,  1, 0, 0, 2'b00, 0, 32'h0000CCCC, 32'h0,        0, 0, 0,  32'h0,        0};
      v[17] = '{1, 0, 0, 6,  1, 0, 0, 2'b00, 0, 32'hDEADBEEF, 32'h0,        1, 1, 6,  32'hDEADBEEF, 1};

      rst = 0; load_data = LD; idle();
      repeat (2) @(negedge clk);
      check_write("reset", 0, 1, 5'd0, 32'd0);
      rst = 1;
      @(posedge clk); #1;
      check_write("post-reset idle", 0, 1, 5'd0, 32'd0);

      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         mem_valid = v[i].valid; wb_hold = v[i].hold; flush = v[i].fl;
         mem_dest = v[i].dest; mem_regwrite = v[i].rw; mem_memtoreg = v[i].m2r;
         mem_link = v[i].link; load_size = v[i].size; load_unsigned = v[i].uns;
         alu_result = v[i].alu; pc_plus4 = v[i].pc;
         #1 check($sformatf("vec%0d mem_ready", i), {31'd0, mem_ready}, {31'd0, !v[i].hold});
         @(posedge clk); #1;
         if (v[i].inc) cnt_exp++;
         check_write($sformatf("vec%0d", i), v[i].exp_rw, v[i].chk, v[i].exp_reg, v[i].exp_data);
      end

      // write pulse followed by hold: strobe falls, address/data held
      @(negedge clk); idle(); beat(5'd7, 32'h77);
      @(posedge clk); #1; cnt_exp++;
      check_write("hold pre", 1, 1, 5'd7, 32'h77);
      @(negedge clk); beat(5'd9, 32'h99); wb_hold = 1;
      #1 check("hold mem_ready", {31'd0, mem_ready}, 32'd0);
      @(posedge clk); #1;
      check_write("hold once", 0, 1, 5'd7, 32'h77);
      @(posedge clk); #1;
      check_write("hold twice", 0, 1, 5'd7, 32'h77);

      // flush does not cancel a write already on the port
      @(negedge clk); idle(); beat(5'd20, 32'h2020);
      @(posedge clk); #1; cnt_exp++;
      @(negedge clk); beat(5'd21, 32'h2121); flush = 1;
      #1 check_write("flush inflight", 1, 1, 5'd20, 32'h2020);
      @(posedge clk); #1;
      check_write("flush drop", 0, 1, 5'd20, 32'h2020);

      // asynchronous reset mid-operation; beat offered during reset is lost
      @(negedge clk); idle(); beat(5'd22, 32'h22);
      @(posedge clk); #1; cnt_exp++;
      check_write("pre-rst", 1, 1, 5'd22, 32'h22);
      #2 rst = 0; cnt_exp = 0;
      #1 check_write("async rst", 0, 1, 5'd0, 32'd0);
      @(posedge clk); #1;
      check_write("beat in rst", 0, 1, 5'd0, 32'd0);
      @(negedge clk); rst = 1; idle();
      @(posedge clk); #1;
      check_write("after rst", 0, 1, 5'd0, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
